// File: rtl/agc_stats_pkg.sv
// rtl/agc_stats_pkg.sv - shared state type, flush depth and width helpers for agc_stats
package agc_stats_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int FLUSH_CYCLES = 2;

   function automatic int clog2(input int value);
      int r;
      int x;
      r = 0;
      x = value - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

   function automatic int sq_bits(input int nbits);
      return 2 * (nbits - 1);
   endfunction

   // Sized for every sample at full scale over the longest window, so no wrap.
   function automatic int acc_bits(input int nsamp, input int nbits, input int win_bits);
      return sq_bits(nbits) + clog2(nsamp) + win_bits;
   endfunction

   function automatic int cnt_bits(input int nsamp, input int win_bits);
      return clog2(nsamp + 1) + win_bits;
   endfunction

endpackage

// File: rtl/agc_stats_tree.sv
// rtl/agc_stats_tree.sv - registered N-input unsigned adder, one pipeline stage
module agc_stats_tree #(
   parameter int N  = 8,
   parameter int W  = 8,
   parameter int OW = 11
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [N*W-1:0]  data,
   output logic [OW-1:0]   sum
);

   logic [OW-1:0] total;

   always_comb begin
      total = '0;
      for (int k = 0; k < N; k++) begin
         total = total + OW'(data[k*W +: W]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sum <= '0;
      end else begin
         sum <= total;
      end
   end

endmodule

// File: rtl/agc_stats.sv
// rtl/agc_stats.sv - windowed sum of squares and gt/lt counts behind the AGC slices
// Optional linear abs sum enabled by AGC_STATS_ABS_SUM_EN.
module agc_stats
   import agc_stats_pkg::*;
#(
   parameter int NSAMP    = 8,
   parameter int NBITS    = 5,
   parameter int WIN_BITS = 24
) (
   input  logic                                       clk_i,
   input  logic                                       rstn_i,
   input  logic [NSAMP*(NBITS-1)-1:0]                 abs_i,
   input  logic [NSAMP-1:0]                           gt_i,
   input  logic [NSAMP-1:0]                           lt_i,
   input  logic [WIN_BITS-1:0]                        period_i,
   input  logic                                       start_i,
   input  logic                                       ack_i,
   output logic                                       busy_o,
   output logic                                       done_o,
   output logic [acc_bits(NSAMP,NBITS,WIN_BITS)-1:0]  sq_sum_o,
   output logic [cnt_bits(NSAMP,WIN_BITS)-1:0]        gt_count_o,
   output logic [cnt_bits(NSAMP,WIN_BITS)-1:0]        lt_count_o,
   output logic [acc_bits(NSAMP,NBITS,WIN_BITS)-1:0]  abs_sum_o
);

   localparam int AW      = NBITS - 1;
   localparam int SQ      = sq_bits(NBITS);
   localparam int ACC     = acc_bits(NSAMP, NBITS, WIN_BITS);
   localparam int CNT     = cnt_bits(NSAMP, WIN_BITS);
   localparam int FW      = clog2(NSAMP + 1);
   localparam int SQ_TREE = SQ + clog2(NSAMP);

   state_t              state;
   state_t              next;
   logic [WIN_BITS-1:0] count;
   logic [1:0]          flush_cnt;
   logic                run;
   logic                accept;
   logic                last_flush;

   assign run        = (state == RUN);
   assign accept     = start_i && ((state == IDLE) || (state == DONE));
   assign last_flush = (state == FLUSH) && (flush_cnt == 2'(FLUSH_CYCLES - 1));
   assign busy_o     = (state == RUN) || (state == FLUSH);
   assign done_o     = (state == DONE);

   always_comb begin
      next = state;
      case (state)
         IDLE:    if (start_i) next = RUN;
         RUN:     if (count == WIN_BITS'(1)) next = FLUSH;
         FLUSH:   if (last_flush) next = DONE;
         DONE: begin
            if (start_i)    next = RUN;
            else if (ack_i) next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state <= IDLE;
      end else begin
         state <= next;
      end
   end

   // Stage 1: squares and flags, forced to zero outside RUN so idle data never reaches the sums.
   logic [NSAMP*SQ-1:0] sq_next;
   logic [NSAMP*SQ-1:0] sq_reg;
   logic [NSAMP-1:0]    gt_reg;
   logic [NSAMP-1:0]    lt_reg;

   always_comb begin
      sq_next = '0;
      for (int k = 0; k < NSAMP; k++) begin
         if (run) begin
            sq_next[k*SQ +: SQ] = SQ'(abs_i[k*AW +: AW]) * SQ'(abs_i[k*AW +: AW]);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         sq_reg <= '0;
         gt_reg <= '0;
         lt_reg <= '0;
      end else begin
         sq_reg <= sq_next;
         gt_reg <= run ? gt_i : '0;
         lt_reg <= run ? lt_i : '0;
      end
   end

   logic [SQ_TREE-1:0] sq_part;
   logic [FW-1:0]      gt_part;
   logic [FW-1:0]      lt_part;

   agc_stats_tree #(.N(NSAMP), .W(SQ), .OW(SQ_TREE)) u_sq_tree (
      .clk(clk_i), .rstn(rstn_i), .data(sq_reg), .sum(sq_part)
   );
   agc_stats_tree #(.N(NSAMP), .W(1), .OW(FW)) u_gt_tree (
      .clk(clk_i), .rstn(rstn_i), .data(gt_reg), .sum(gt_part)
   );
   agc_stats_tree #(.N(NSAMP), .W(1), .OW(FW)) u_lt_tree (
      .clk(clk_i), .rstn(rstn_i), .data(lt_reg), .sum(lt_part)
   );

   logic [ACC-1:0] sq_acc;
   logic [CNT-1:0] gt_acc;
   logic [CNT-1:0] lt_acc;

   // Results load from acc + last partial so they change exactly as done_o rises.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         count      <= '0;
         flush_cnt  <= '0;
         sq_acc     <= '0;
         gt_acc     <= '0;
         lt_acc     <= '0;
         sq_sum_o   <= '0;
         gt_count_o <= '0;
         lt_count_o <= '0;
      end else begin
         flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
         if (accept) begin
            count      <= (period_i == '0) ? WIN_BITS'(1) : period_i;
            sq_acc     <= '0;
            gt_acc     <= '0;
            lt_acc     <= '0;
            sq_sum_o   <= '0;
            gt_count_o <= '0;
            lt_count_o <= '0;
         end else begin
            if (run) count <= count - WIN_BITS'(1);
            sq_acc <= sq_acc + ACC'(sq_part);
            gt_acc <= gt_acc + CNT'(gt_part);
            lt_acc <= lt_acc + CNT'(lt_part);
            if (last_flush) begin
               sq_sum_o   <= sq_acc + ACC'(sq_part);
               gt_count_o <= gt_acc + CNT'(gt_part);
               lt_count_o <= lt_acc + CNT'(lt_part);
            end
         end
      end
   end

`ifdef AGC_STATS_ABS_SUM_EN
   localparam int ABS_TREE = AW + clog2(NSAMP);

   logic [NSAMP*AW-1:0] abs_reg;
   logic [ABS_TREE-1:0] abs_part;
   logic [ACC-1:0]      abs_acc;

   agc_stats_tree #(.N(NSAMP), .W(AW), .OW(ABS_TREE)) u_abs_tree (
      .clk(clk_i), .rstn(rstn_i), .data(abs_reg), .sum(abs_part)
   );

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         abs_reg   <= '0;
         abs_acc   <= '0;
         abs_sum_o <= '0;
      end else begin
         abs_reg <= run ? abs_i : '0;
         if (accept) begin
            abs_acc   <= '0;
            abs_sum_o <= '0;
         end else begin
            abs_acc <= abs_acc + ACC'(abs_part);
            if (last_flush) abs_sum_o <= abs_acc + ACC'(abs_part);
         end
      end
   end
`else
   assign abs_sum_o = '0;
`endif

endmodule
